// File: rtl/axi4_mem_arb_pkg.sv
// axi4_mem_arb_pkg: shared state type, port indices and parameter defaults for axi4_mem_arbiter
package axi4_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_WR,
        GNT_RD
    } arb_state_t;

    localparam int WR = 0;
    localparam int RD = 1;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_MEMORY_DEPTH = 1024;
    localparam int DEF_MAX_HOLD     = 16;

endpackage

// File: rtl/axi4_mem_arbiter.sv
// axi4_mem_arbiter: two-engine (write/read) arbiter for a single-port memory with burst-locked grants
// Optional macro ARB_HOLD_LIMIT_EN: preempt a grant after MAX_HOLD beats when the other engine waits.
module axi4_mem_arbiter
    import axi4_mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int MEMORY_DEPTH = DEF_MEMORY_DEPTH,
    parameter int MAX_HOLD     = DEF_MAX_HOLD,
    localparam int AW          = $clog2(MEMORY_DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  wr_req,
    input  logic                  wr_last,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_wdata,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic                  rd_last,
    input  logic [AW-1:0]         rd_addr,
    output logic                  rd_gnt,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  rd_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_hold_range
        $error("MAX_HOLD must be in 1..255");
    end

    arb_state_t state, state_nxt;
    logic       last_srv;
    logic [1:0] req, beat, done;
    logic       hold_hit;

    assign req[WR]  = wr_req;
    assign req[RD]  = rd_req;
    assign beat[WR] = (state == GNT_WR) && wr_req;
    assign beat[RD] = (state == GNT_RD) && rd_req;
    assign done[WR] = beat[WR] && wr_last;
    assign done[RD] = beat[RD] && rd_last;

    assign wr_gnt    = state == GNT_WR;
    assign rd_gnt    = state == GNT_RD;
    assign mem_en    = |beat;
    assign mem_we    = state == GNT_WR;
    assign mem_addr  = beat[WR] ? wr_addr : beat[RD] ? rd_addr : '0;
    assign mem_wdata = beat[WR] ? wr_wdata : '0;
    assign rd_rdata  = mem_rdata;

`ifdef ARB_HOLD_LIMIT_EN
    logic [8:0] cnt, cnt_inc;

    assign cnt_inc  = cnt + 9'(|beat);
    assign hold_hit = cnt_inc >= 9'(MAX_HOLD);

    // Beats in the current grant, saturating at MAX_HOLD and cleared on every grant change
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            cnt <= '0;
        else
            cnt <= (state_nxt != state) ? '0 : hold_hit ? 9'(MAX_HOLD) : cnt_inc;
    end
`else
    assign hold_hit = 1'b0;
`endif

    // Grant selection: alternate on contention, lock until last (or hold limit), hand over without a gap
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (req[WR] && (!req[RD] || last_srv == 1'(RD))) ? GNT_WR :
                                 req[RD] ? GNT_RD : IDLE;
            GNT_WR:  state_nxt = (done[WR] || (hold_hit && req[RD])) ? (req[RD] ? GNT_RD : IDLE) : GNT_WR;
            GNT_RD:  state_nxt = (done[RD] || (hold_hit && req[WR])) ? (req[WR] ? GNT_WR : IDLE) : GNT_RD;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, last-served port and the one-cycle-delayed read valid
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            last_srv  <= 1'(RD);
            rd_rvalid <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_rvalid <= beat[RD];
            if (state_nxt != state && state_nxt != IDLE)
                last_srv <= (state_nxt == GNT_RD) ? 1'(RD) : 1'(WR);
        end
    end

endmodule

// File: doc/axi4_mem_arbiter.md
AXI4_MEM_ARBITER -- requirements
Module: axi4_mem_arbiter
Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data word width of every wdata/rdata port.
REQ-002 Parameter MEMORY_DEPTH, default 1024, SHALL set memory words; every address port SHALL be $clog2(MEMORY_DEPTH) bits wide (AW).
REQ-003 Parameter MAX_HOLD, default 16, range 1..255, SHALL set the maximum number of consecutive granted beats before fairness preemption.
REQ-004 ACLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 ARESETn  input  1  asynchronous, active-low reset.
REQ-006 wr_req  input  1  write engine requests one memory write this cycle.
REQ-007 wr_last  input  1  the current write beat is the final beat of its burst.
REQ-008 wr_addr  input  AW  write word address.
REQ-009 wr_wdata  input  DATA_WIDTH  write data.
REQ-010 wr_gnt  output  1  write engine owns the memory port.
REQ-011 rd_req  input  1  read engine requests one memory read this cycle.
REQ-012 rd_last  input  1  the current read beat is the final beat of its burst.
REQ-013 rd_addr  input  AW  read word address.
REQ-014 rd_gnt  output  1  read engine owns the memory port.
REQ-015 rd_rdata  output  DATA_WIDTH  read data, a direct pass-through of mem_rdata.
REQ-016 rd_rvalid  output  1  rd_rdata is valid this cycle.
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_we  output  1  1 = write, 0 = read; meaningful only while mem_en=1.
REQ-019 mem_addr  output  AW  memory address.
REQ-020 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-021 mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after a read access.
Function
REQ-022 The FSM SHALL have exactly three states: IDLE, GNT_WR and GNT_RD; wr_gnt SHALL be 1 only in GNT_WR and rd_gnt only in GNT_RD.
REQ-023 From IDLE: a single requester SHALL be granted on the next cycle; if both request, the grant SHALL go to the port not served last (reset value: write first).
REQ-024 A beat SHALL occur on each cycle with gnt&req=1, and mem_en, mem_we, mem_addr and mem_wdata SHALL be driven combinationally from the granted port in that same cycle.
REQ-025 mem_we SHALL equal 1 in GNT_WR and 0 otherwise; mem_wdata SHALL be 0 when no write beat is occurring.
REQ-026 The grant SHALL lock until a beat with last=1; a granted port dropping req without last SHALL keep the grant, with mem_en held at 0 for that cycle.
REQ-027 After the last beat, the other port SHALL be granted on the next cycle if it is requesting (no idle gap); otherwise the FSM SHALL return to IDLE.
REQ-028 rd_rvalid SHALL be a registered copy of (read beat occurring), asserting exactly one cycle after each read beat, independent of the current grant.
REQ-029 A beat counter SHALL count beats in the current grant and SHALL clear on every grant change.
REQ-030 The last-served register SHALL update on every grant change.
Reset
REQ-031 While ARESETn=0, the FSM SHALL be in IDLE, the counter 0, last-served = read (so write wins first), and wr_gnt, rd_gnt, rd_rvalid, mem_en, mem_we, mem_addr and mem_wdata SHALL all be 0, taking effect immediately without a clock.
REQ-032 A reset mid-burst SHALL abandon the burst; after release, arbitration SHALL restart from IDLE.
Configuration
REQ-033 With ARB_HOLD_LIMIT_EN defined: when the counter reaches MAX_HOLD beats and the other port is requesting, the grant SHALL pass to the other port on the next cycle even without last; the preempted port resumes mid-burst on a later grant.
REQ-034 Without ARB_HOLD_LIMIT_EN: there SHALL be no preemption, bursts SHALL run to last, and the counter SHALL be omitted.
Structure
REQ-035 Package axi4_mem_arb_pkg SHALL hold the state enum typedef, the port index constants (WR=0, RD=1) and the default DATA_WIDTH, MEMORY_DEPTH and MAX_HOLD values.
REQ-036 The block SHALL be a single module with no sub-module.
Verification
REQ-037 Write-only burst of 4 beats at addresses 0x010..0x013 with last on beat 4 -> 4 mem_en=1, mem_we=1 cycles with matching address and data, then IDLE.
REQ-038 wr_req and rd_req both rise from IDLE after reset -> write is granted first; after its last beat, read is granted on the next cycle with no gap.
REQ-039 Read of 2 beats with memory preloaded 0xDEADBEEF at 0x3FF -> rd_rvalid=1 with rd_rdata=0xDEADBEEF one cycle after the beat.
REQ-040 ARB_HOLD_LIMIT_EN, MAX_HOLD=4, 10-beat write burst with rd_req held -> grant switches to read after beat 4, and the write resumes after the read's last beat.
REQ-041 ARESETn pulsed low on beat 2 of a write burst -> wr_gnt and mem_en drop immediately, and the FSM is in IDLE after release.
